char_motion_ctrl: RTL and testbench

- Upstream of the screen renderer; produces the character position (charactor_h, charactor_v) and facing direction (charactor_dir) that the renderer draws.
- On each movement tick, reads button levels and computes a candidate position. It then checks the four sprite corners against the tile map, one corner per cycle, and commits or rejects the move.
- Flags arrival on TERMINAL and STAR tiles for the game-state FSM.

---
 rtl/char_motion_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_char_motion_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/char_motion_ctrl.sv
// char_motion_ctrl: moves the player sprite on the 20x15 tile map.
// On each movement tick the button levels select a one-axis step. The block
// then checks the four sprite corners against the map, one corner per cycle,
// and commits or rejects the move. It flags arrival on TERMINAL / STAR tiles.
// Optional build macro DIAG_MOVE_EN: horizontal + vertical presses move
// diagonally, falling back to horizontal-only and then vertical-only if blocked.
module char_motion_ctrl #(
    parameter logic [8:0] START_H = 9'd24,
    parameter logic [8:0] START_V = 9'd24,
    parameter logic [3:0] STEP    = 4'd2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         move_tick,
    input  logic         game_active,
    input  logic         load_start,
    input  logic         btn_left,
    input  logic         btn_right,
    input  logic         btn_up,
    input  logic         btn_down,
    input  logic [0:899] map,
    output logic [8:0]   charactor_h,
    output logic [8:0]   charactor_v,
    output logic         charactor_dir,
    output logic         busy,
    output logic         reached_terminal,
    output logic         star_hit,
    output logic [8:0]   star_tile
);

    localparam logic [9:0] H_MIN = 10'd7;
    localparam logic [9:0] H_MAX = 10'd311;
    localparam logic [9:0] V_MIN = 10'd7;
    localparam logic [9:0] V_MAX = 10'd231;

    // Which candidate the corner check is currently testing
    localparam logic [1:0] TRY_SINGLE = 2'd0;
    localparam logic [1:0] TRY_DIAG   = 2'd1;
    localparam logic [1:0] TRY_HORIZ  = 2'd2;
    localparam logic [1:0] TRY_VERT   = 2'd3;

    typedef enum logic [2:0] {IDLE, CALC, CHK, COMMIT, DONE} state_t;

    state_t     state_q, state_d;
    logic [1:0] corner_q, corner_d;
    logic [1:0] try_q, try_d;
    logic [8:0] nh_q, nh_d, nv_q, nv_d;
    logic [8:0] h_q, h_d, v_q, v_d;
    logic [8:0] star_tile_q, star_tile_d;
    logic       dir_q, dir_d;
    logic       busy_q, busy_d;
    logic       term_q, term_d;
    logic       star_q, star_d;

    logic       horiz_valid, vert_valid;
    logic [8:0] cand_h, cand_v;
    logic [8:0] eff_h, eff_v;
    logic [9:0] cx, cy;
    logic [2:0] corner_code, centre_code;
    logic [9:0] centre_idx;
`ifdef DIAG_MOVE_EN
    logic       h_ok, v_ok;
`endif

    // One STEP toward inc/dec, clamped into [lo, hi]; done at 10 bits so nothing wraps
    function automatic logic [8:0] step_pos(input logic [8:0] cur, input logic inc,
                                            input logic [9:0] lo, input logic [9:0] hi);
        logic [9:0] c;
        logic [9:0] s;
        c = {1'b0, cur};
        s = {6'd0, STEP};
        if (inc) begin
            return (c + s > hi) ? 9'(hi) : 9'(c + s);
        end
        return (c < lo + s) ? 9'(lo) : 9'(c - s);
    endfunction

    function automatic logic [9:0] tile_index(input logic [9:0] x, input logic [9:0] y);
        logic [9:0] col;
        logic [9:0] row;
        col = x >> 4;
        row = y >> 4;
        return col + row * 10'd20;
    endfunction

    // Tile codes are stored MSB-first, three bits per tile
    function automatic logic [2:0] tile_code(input logic [0:899] m, input logic [9:0] idx);
        logic [10:0] base;
        base = {1'b0, idx} * 11'd3;
        return m[base +: 3];
    endfunction

    function automatic logic walkable(input logic [2:0] code);
        return (code == 3'd1) || (code == 3'd2) || (code == 3'd3);
    endfunction

    // Button decode, step candidates and the map lookups for the current corner and centre
    always_comb begin
        horiz_valid = btn_left ^ btn_right;
        vert_valid  = btn_up ^ btn_down;
        cand_h      = step_pos(h_q, btn_right, H_MIN, H_MAX);
        cand_v      = step_pos(v_q, btn_down, V_MIN, V_MAX);
        eff_h       = (try_q == TRY_VERT)  ? h_q : nh_q;
        eff_v       = (try_q == TRY_HORIZ) ? v_q : nv_q;
        cx          = corner_q[0] ? ({1'b0, eff_h} + 10'd8) : ({1'b0, eff_h} - 10'd7);
        cy          = corner_q[1] ? ({1'b0, eff_v} + 10'd8) : ({1'b0, eff_v} - 10'd7);
        corner_code = tile_code(map, tile_index(cx, cy));
        centre_idx  = tile_index({1'b0, eff_h}, {1'b0, eff_v});
        centre_code = tile_code(map, centre_idx);
`ifdef DIAG_MOVE_EN
        h_ok        = horiz_valid && (cand_h != h_q);
        v_ok        = vert_valid && (cand_v != v_q);
`endif
    end

    // Next-state logic for the move FSM and every registered output
    always_comb begin
        state_d     = state_q;
        corner_d    = corner_q;
        try_d       = try_q;
        nh_d        = nh_q;
        nv_d        = nv_q;
        h_d         = h_q;
        v_d         = v_q;
        dir_d       = dir_q;
        star_tile_d = star_tile_q;
        term_d      = 1'b0;
        star_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (load_start) begin
                    h_d = START_H;
                    v_d = START_V;
                end else if (move_tick && game_active) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                corner_d = 2'd0;
                try_d    = TRY_SINGLE;
                if (horiz_valid) begin
                    dir_d = btn_right;
                end
`ifdef DIAG_MOVE_EN
                nh_d    = h_ok ? cand_h : h_q;
                nv_d    = v_ok ? cand_v : v_q;
                try_d   = (h_ok && v_ok) ? TRY_DIAG : TRY_SINGLE;
                state_d = (h_ok || v_ok) ? CHK : IDLE;
`else
                if (horiz_valid) begin
                    nh_d    = cand_h;
                    nv_d    = v_q;
                    state_d = (cand_h != h_q) ? CHK : IDLE;
                end else if (vert_valid) begin
                    nh_d    = h_q;
                    nv_d    = cand_v;
                    state_d = (cand_v != v_q) ? CHK : IDLE;
                end else begin
                    state_d = IDLE;
                end
`endif
            end
            CHK: begin
                if (!walkable(corner_code)) begin
`ifdef DIAG_MOVE_EN
                    if (try_q == TRY_DIAG || try_q == TRY_HORIZ) begin
                        try_d    = try_q + 2'd1;
                        corner_d = 2'd0;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end else if (corner_q == 2'd3) begin
                    state_d = COMMIT;
                end else begin
                    corner_d = corner_q + 2'd1;
                end
            end
            COMMIT: begin
                h_d     = eff_h;
                v_d     = eff_v;
                state_d = DONE;
            end
            DONE: begin
                if (centre_code == 3'd2) begin
                    term_d = 1'b1;
                end
                if (centre_code == 3'd3) begin
                    star_d      = 1'b1;
                    star_tile_d = 9'(centre_idx);
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            corner_q    <= 2'd0;
            try_q       <= TRY_SINGLE;
            nh_q        <= START_H;
            nv_q        <= START_V;
            h_q         <= START_H;
            v_q         <= START_V;
            dir_q       <= 1'b1;
            busy_q      <= 1'b0;
            term_q      <= 1'b0;
            star_q      <= 1'b0;
            star_tile_q <= 9'd0;
        end else begin
            state_q     <= state_d;
            corner_q    <= corner_d;
            try_q       <= try_d;
            nh_q        <= nh_d;
            nv_q        <= nv_d;
            h_q         <= h_d;
            v_q         <= v_d;
            dir_q       <= dir_d;
            busy_q      <= busy_d;
            term_q      <= term_d;
            star_q      <= star_d;
            star_tile_q <= star_tile_d;
        end
    end

    assign charactor_h      = h_q;
    assign charactor_v      = v_q;
    assign charactor_dir    = dir_q;
    assign busy             = busy_q;
    assign reached_terminal = term_q;
    assign star_hit         = star_q;
    assign star_tile        = star_tile_q;

endmodule

// File: tb/tb_char_motion_ctrl.sv
// Testbench for char_motion_ctrl: directed moves over a bench-owned tile map,
// with expected positions/flags produced by a small behavioural model.
module tb_char_motion_ctrl;

    localparam int STEP = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         move_tick = 1'b0;
    logic         game_active = 1'b0;
    logic         load_start = 1'b0;
    logic         btn_left = 1'b0;
    logic         btn_right = 1'b0;
    logic         btn_up = 1'b0;
    logic         btn_down = 1'b0;
    logic [0:899] map_tb;
    logic [8:0]   charactor_h;
    logic [8:0]   charactor_v;
    logic         charactor_dir;
    logic         busy;
    logic         reached_terminal;
    logic         star_hit;
    logic [8:0]   star_tile;

    typedef struct {
        int h;
        int v;
        int dir;
        int term;
        int star;
        int tile;
    } exp_t;

    exp_t exp_q[$];

    int total = 0;
    int bad = 0;
    int m_h, m_v, m_dir, m_tile;
    int term_cnt, star_cnt;

    char_motion_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .move_tick        (move_tick),
        .game_active      (game_active),
        .load_start       (load_start),
        .btn_left         (btn_left),
        .btn_right        (btn_right),
        .btn_up           (btn_up),
        .btn_down         (btn_down),
        .map              (map_tb),
        .charactor_h      (charactor_h),
        .charactor_v      (charactor_v),
        .charactor_dir    (charactor_dir),
        .busy             (busy),
        .reached_terminal (reached_terminal),
        .star_hit         (star_hit),
        .star_tile        (star_tile)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int actual, input int expected);
        total++;
        assert (actual === expected) else begin
            bad++;
            $error("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    function automatic int tileAt(input int x, input int y);
        int idx;
        idx = (x / 16) + (y / 16) * 20;
        return {29'd0, map_tb[idx*3], map_tb[idx*3+1], map_tb[idx*3+2]};
    endfunction

    task automatic setTile(input int idx, input int code);
        logic [2:0] c;
        c = 3'(code);
        map_tb[idx*3]   = c[2];
        map_tb[idx*3+1] = c[1];
        map_tb[idx*3+2] = c[0];
    endtask

    task automatic fillMap(input int code);
        for (int i = 0; i < 300; i++) setTile(i, code);
    endtask

    // Behavioural reference: one movement tick, result pushed to the scoreboard
    task automatic modelStep(input bit l, input bit r, input bit u, input bit d);
        int nh, nv, code, e_term, e_star;
        bit go, ok;
        int dx[4] = '{-7, 8, -7, 8};
        int dy[4] = '{-7, -7, 8, 8};
        nh = m_h;
        nv = m_v;
        go = 1'b0;
        e_term = 0;
        e_star = 0;
        if (game_active) begin
            if (l != r) begin
                m_dir = r ? 1 : 0;
                if (r) nh = (m_h + STEP > 311) ? 311 : m_h + STEP;
                else   nh = (m_h - STEP < 7) ? 7 : m_h - STEP;
                go = (nh != m_h);
            end else if (u != d) begin
                if (d) nv = (m_v + STEP > 231) ? 231 : m_v + STEP;
                else   nv = (m_v - STEP < 7) ? 7 : m_v - STEP;
                go = (nv != m_v);
            end
        end
        if (go) begin
            ok = 1'b1;
            for (int i = 0; i < 4; i++) begin
                code = tileAt(nh + dx[i], nv + dy[i]);
                if (code < 1 || code > 3) ok = 1'b0;
            end
            if (ok) begin
                m_h = nh;
                m_v = nv;
                code = tileAt(nh, nv);
                if (code == 2) e_term = 1;
                if (code == 3) begin
                    e_star = 1;
                    m_tile = (nh / 16) + (nv / 16) * 20;
                end
            end
        end
        exp_q.push_back('{m_h, m_v, m_dir, e_term, e_star, m_tile});
    endtask

    // Drive buttons, record the expected outcome, pulse move_tick for one cycle
    task automatic applyStimulus(input bit l, input bit r, input bit u, input bit d);
        @(negedge clk);
        btn_left  = l;
        btn_right = r;
        btn_up    = u;
        btn_down  = d;
        modelStep(l, r, u, d);
        move_tick = 1'b1;
        @(negedge clk);
        move_tick = 1'b0;
    endtask

    // Watch 12 cycles for flag pulses; mode 1 checks move latency, mode 2 checks
    // that a clamped-to-current move leaves after CALC without any corner checks
    task automatic waitWindow(input int mode, input int old_h, input int new_h);
        term_cnt = 0;
        star_cnt = 0;
        if (mode != 0) check("busy_after_tick", int'(busy), 1);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (reached_terminal) term_cnt++;
            if (star_hit) star_cnt++;
            if (mode == 1 && k == 5) begin
                check("lat_h_before", int'(charactor_h), old_h);
                check("busy_mid", int'(busy), 1);
            end
            if (mode == 1 && k == 6) check("lat_h_after", int'(charactor_h), new_h);
            if (mode == 2 && k == 1) check("clamp_no_chk", int'(busy), 0);
        end
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 0, 1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_h"}, int'(charactor_h), e.h);
            check({tag, "_v"}, int'(charactor_v), e.v);
            check({tag, "_dir"}, int'(charactor_dir), e.dir);
            check({tag, "_term"}, term_cnt, e.term);
            check({tag, "_star"}, star_cnt, e.star);
            check({tag, "_tile"}, int'(star_tile), e.tile);
            check({tag, "_idle"}, int'(busy), 0);
        end
    endtask

    task automatic doLoad();
        @(negedge clk);
        load_start = 1'b1;
        move_tick  = 1'b1;
        btn_right  = 1'b1;
        m_h = 24;
        m_v = 24;
        exp_q.push_back('{m_h, m_v, m_dir, 0, 0, m_tile});
        @(negedge clk);
        load_start = 1'b0;
        move_tick  = 1'b0;
        btn_right  = 1'b0;
        check("load_no_move", int'(busy), 0);
        waitWindow(0, 0, 0);
        checkOutput("load");
    endtask

    initial begin
        fillMap(1);
        m_h = 24; m_v = 24; m_dir = 1; m_tile = 0;

        // Reset held for two cycles
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_h", int'(charactor_h), 24);
        check("rst_v", int'(charactor_v), 24);
        check("rst_dir", int'(charactor_dir), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_term", int'(reached_terminal), 0);
        check("rst_star", int'(star_hit), 0);
        check("rst_tile", int'(star_tile), 0);

        // Open corridor with exact latency
        game_active = 1'b1;
        applyStimulus(0, 1, 0, 0);
        waitWindow(1, 24, 26);
        checkOutput("corridor");

        doLoad();

        // Walls left and right of the start tile
        setTile(22, 0);
        setTile(20, 0);
        applyStimulus(0, 1, 0, 0);
        waitWindow(0, 0, 0);
        checkOutput("wall_right");
        applyStimulus(1, 0, 0, 0);
        waitWindow(0, 0, 0);
        checkOutput("wall_left");
        fillMap(1);

        // Opposing buttons, then vertical moves
        applyStimulus(1, 1, 0, 0);
        waitWindow(0, 0, 0);
        checkOutput("opposing");
        applyStimulus(0, 0, 1, 0);
        waitWindow(0, 0, 0);
        checkOutput("up");
        applyStimulus(0, 0, 0, 1);
        waitWindow(0, 0, 0);
        checkOutput("down");

        // Ticks are ignored outside GAME
        game_active = 1'b0;
        applyStimulus(0, 1, 0, 0);
        waitWindow(0, 0, 0);
        checkOutput("inactive");
        game_active = 1'b1;

        // A second tick while busy is dropped
        applyStimulus(0, 1, 0, 0);
        repeat (2) @(negedge clk);
        move_tick = 1'b1;
        @(negedge clk);
        move_tick = 1'b0;
        waitWindow(0, 0, 0);
        checkOutput("dropped");

        // Terminal tile under the new centre
        doLoad();
        setTile(21, 2);
        applyStimulus(0, 1, 0, 0);
        waitWindow(0, 0, 0);
        checkOutput("terminal");
        setTile(21, 1);

        // Walk to the star tile at index 45
        setTile(45, 3);
        for (int i = 0; i < 27; i++) begin
            applyStimulus(0, 1, 0, 0);
            waitWindow(0, 0, 0);
            checkOutput("to_star_h");
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 1);
            waitWindow(0, 0, 0);
            checkOutput("to_star_v");
        end
        check("star_idx", int'(star_tile), 45);

        // Right edge clamp
        for (int i = 0; i < 116; i++) begin
            applyStimulus(0, 1, 0, 0);
            waitWindow(0, 0, 0);
            checkOutput("to_edge");
        end
        check("edge_h", int'(charactor_h), 311);
        applyStimulus(0, 1, 0, 0);
        waitWindow(2, 0, 0);
        checkOutput("edge_hold");

        // Reset in the middle of a move
        doLoad();
        @(negedge clk);
        btn_left  = 1'b1;
        btn_right = 1'b0;
        move_tick = 1'b1;
        @(negedge clk);
        move_tick = 1'b0;
        @(negedge clk);
        check("midrst_dir_set", int'(charactor_dir), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        btn_left = 1'b0;
        check("midrst_dir", int'(charactor_dir), 1);
        check("midrst_busy", int'(busy), 0);
        repeat (10) @(negedge clk);
        check("midrst_h", int'(charactor_h), 24);
        check("midrst_tile", int'(star_tile), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
